// File: rtl/vrf_wb_ctrl.sv
// rtl/vrf_wb_ctrl.sv - vector register file write-back controller
// Accepts one lane-result bundle and streams its elements to the VRF one per cycle.
module vrf_wb_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_NUM    = 32,
  parameter int LANES      = 4,
  localparam int ADDR_B    = $clog2(REG_NUM),
  localparam int ELEM_B    = $clog2(LANES)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        res_valid_i,
  output logic                        res_ready_o,
  input  logic [ADDR_B-1:0]           res_addr_i,
  input  logic [LANES*DATA_WIDTH-1:0] res_data_i,
  input  logic [LANES-1:0]            res_mask_i,
  output logic                        wr_req_o,
  output logic                        wr_en_o,
  output logic                        wr_ready_o,
  output logic [ADDR_B-1:0]           wr_addr_o,
  output logic [ELEM_B-1:0]           wr_elem_cnt_o,
  output logic [DATA_WIDTH-1:0]       wdata_o,
  output logic                        busy_o,
  output logic                        done_o
);

  typedef enum logic [1:0] {IDLE, REQ, WRITE, DONE} state_t;

  state_t                      state_q, state_d;
  logic [ELEM_B-1:0]           cnt_q;
  logic [ADDR_B-1:0]           addr_q;
  logic [LANES*DATA_WIDTH-1:0] data_q;
  logic [LANES-1:0]            mask_q;
  logic                        zdone_q;
  logic                        hs;
  logic [DATA_WIDTH-1:0]       lane [LANES];

  assign hs = res_valid_i && res_ready_o;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign lane[g] = data_q[g*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs && (res_mask_i != '0)) state_d = REQ;
      REQ:     state_d = WRITE;
      WRITE:   if (cnt_q == ELEM_B'(LANES-1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // An all-zero mask retires in IDLE; zdone_q supplies its registered done pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      zdone_q <= 1'b0;
    end else begin
      zdone_q <= hs && (res_mask_i == '0);
      if (hs) begin
        addr_q <= res_addr_i;
        data_q <= res_data_i;
        mask_q <= res_mask_i;
      end
      if (state_q == REQ) begin
        cnt_q <= '0;
      end else if (state_q == WRITE) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    res_ready_o   = (state_q == IDLE) && !rst_i;
    busy_o        = (state_q != IDLE);
    wr_req_o      = (state_q == REQ);
    wr_en_o       = 1'b0;
    wr_ready_o    = (state_q == DONE);
    done_o        = (state_q == DONE) || zdone_q;
    wr_addr_o     = (state_q != IDLE) ? addr_q : '0;
    wr_elem_cnt_o = '0;
    wdata_o       = '0;
    if (state_q == WRITE) begin
      wr_en_o       = mask_q[cnt_q];
      wr_elem_cnt_o = cnt_q;
      wdata_o       = lane[cnt_q];
    end
  end

endmodule

// File: tb/tb_vrf_wb_ctrl.sv
// tb/tb_vrf_wb_ctrl.sv - self-checking bench for vrf_wb_ctrl
// Queue-based reference model plus directed literal checks and random traffic.
module tb_vrf_wb_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         res_valid;
  logic         res_ready;
  logic [4:0]   res_addr;
  logic [127:0] res_data;
  logic [3:0]   res_mask;
  logic         wr_req, wr_en, wr_ready, busy, done;
  logic [4:0]   wr_addr;
  logic [1:0]   wr_cnt;
  logic [31:0]  wdata;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  vrf_wb_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .res_valid_i(res_valid), .res_ready_o(res_ready),
    .res_addr_i(res_addr), .res_data_i(res_data), .res_mask_i(res_mask),
    .wr_req_o(wr_req), .wr_en_o(wr_en), .wr_ready_o(wr_ready),
    .wr_addr_o(wr_addr), .wr_elem_cnt_o(wr_cnt), .wdata_o(wdata),
    .busy_o(busy), .done_o(done)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    bit        ready, req, en, rdy, done, busy;
    bit [4:0]  addr;
    bit [1:0]  cnt;
    bit [31:0] data;
  } exp_t;

  exp_t q[$];
  exp_t cur;

  function automatic exp_t blank();
    exp_t e;
    e = '{default: 0};
    return e;
  endfunction

  // Expected per-cycle outputs of one accepted bundle, in order.
  task automatic push_bundle(input bit [4:0] a, input bit [127:0] d, input bit [3:0] m);
    exp_t e;
    if (m == 4'b0) begin
      e = blank(); e.ready = 1; e.done = 1;
      q.push_back(e);
      return;
    end
    e = blank(); e.busy = 1; e.addr = a; e.req = 1;
    q.push_back(e);
    for (int i = 0; i < 4; i++) begin
      e = blank(); e.busy = 1; e.addr = a; e.cnt = 2'(i);
      e.en = m[i]; e.data = d[i*32 +: 32];
      q.push_back(e);
    end
    e = blank(); e.busy = 1; e.addr = a; e.rdy = 1; e.done = 1;
    q.push_back(e);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      cur = blank();
    end else begin
      if (res_valid && !cur.busy) push_bundle(res_addr, res_data, res_mask);
      if (q.size() > 0) begin
        cur = q.pop_front();
      end else begin
        cur = blank();
        cur.ready = 1;
      end
    end
    #2;
    chk("res_ready", 32'(res_ready), 32'(cur.ready));
    chk("busy", 32'(busy), 32'(cur.busy));
    chk("done", 32'(done), 32'(cur.done));
    chk("wr_req", 32'(wr_req), 32'(cur.req));
    chk("wr_en", 32'(wr_en), 32'(cur.en));
    chk("wr_ready", 32'(wr_ready), 32'(cur.rdy));
    chk("wr_addr", 32'(wr_addr), 32'(cur.addr));
    chk("elem_cnt", 32'(wr_cnt), 32'(cur.cnt));
    chk("wdata", wdata, cur.data);
    chk("excl", 32'($onehot0({wr_req, wr_en, wr_ready})), 32'd1);
  end

  task automatic drive(input bit v, input bit [4:0] a, input bit [3:0] m, input bit [127:0] d);
    res_valid = v; res_addr = a; res_mask = m; res_data = d;
  endtask

  function automatic bit [127:0] pat(input bit [31:0] base);
    bit [127:0] d;
    for (int i = 0; i < 4; i++) d[i*32 +: 32] = base + 32'(i);
    return d;
  endfunction

  // One bundle with literal expectations; ends at +3 of the IDLE cycle after DONE.
  task automatic directed(input bit [4:0] a, input bit [3:0] m, input bit [31:0] base);
    drive(1, a, m, pat(base));
    @(posedge clk); #3;
    chk("d_req", 32'(wr_req), 32'd1);
    @(negedge clk); res_valid = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #3;
      chk("d_en", 32'(wr_en), 32'(m[i]));
      chk("d_cnt", 32'(wr_cnt), i);
      chk("d_data", wdata, base + 32'(i));
      chk("d_addr", 32'(wr_addr), 32'(a));
    end
    @(posedge clk); #3;
    chk("d_wr_ready", 32'(wr_ready), 32'd1);
    chk("d_done", 32'(done), 32'd1);
    chk("d_en_done", 32'(wr_en), 32'd0);
    @(posedge clk); #3;
    chk("d_ready_after", 32'(res_ready), 32'd1);
    chk("d_busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1;
    drive(0, 0, 0, 0);
    #1;
    chk("rst_ready", 32'(res_ready), 32'd0);
    chk("rst_ctl", 32'({busy, done, wr_req, wr_en, wr_ready}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);

    directed(5'd5, 4'b1111, 32'hA0A0_0000);
    @(negedge clk);
    directed(5'd6, 4'b0101, 32'hB0B0_0000);

    // All-zero mask: no VRF traffic, done pulse next cycle while still ready.
    @(negedge clk);
    drive(1, 5'd9, 4'b0000, pat(32'hC0C0_0000));
    @(posedge clk); #3;
    chk("z_done", 32'(done), 32'd1);
    chk("z_ready", 32'(res_ready), 32'd1);
    chk("z_req", 32'(wr_req), 32'd0);
    @(negedge clk); res_valid = 0;
    @(posedge clk); #3;
    chk("z_done_gone", 32'(done), 32'd0);

    // Valid held high: inputs churn during the first bundle; second accepted after DONE.
    @(negedge clk);
    drive(1, 5'd3, 4'b1111, pat(32'hD0D0_0000));
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #3;
      if (k >= 2 && k <= 5) chk("b2b_data", wdata, 32'hD0D0_0000 + 32'(k - 2));
      if (k == 7) chk("b2b_ready", 32'(res_ready), 32'd1);
      @(negedge clk);
      if (k < 7) drive(1, 5'($urandom), 4'($urandom), {$urandom, $urandom, $urandom, $urandom});
      else       drive(1, 5'd7, 4'b0011, pat(32'hE0E0_0000));
    end
    @(posedge clk); #3;
    chk("b2b_req2", 32'(wr_req), 32'd1);
    chk("b2b_addr2", 32'(wr_addr), 32'd7);
    @(negedge clk); res_valid = 0;
    repeat (6) @(posedge clk);

    // Asynchronous reset in the middle of a write burst.
    @(negedge clk);
    drive(1, 5'd11, 4'b1111, pat(32'hF0F0_0000));
    @(posedge clk);
    @(negedge clk); res_valid = 0;
    repeat (3) @(posedge clk);
    #3;
    chk("ar_cnt", 32'(wr_cnt), 32'd2);
    rst = 1;
    #1;
    chk("ar_ready", 32'(res_ready), 32'd0);
    chk("ar_ctl", 32'({busy, done, wr_req, wr_en, wr_ready}), 32'd0);
    chk("ar_addr", 32'(wr_addr), 32'd0);
    chk("ar_cnt0", 32'(wr_cnt), 32'd0);
    chk("ar_wdata", wdata, 32'd0);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk); rst = 0;
    @(posedge clk); #3;
    chk("ar_ready_after", 32'(res_ready), 32'd1);
    chk("ar_no_done", 32'(done), 32'd0);

    // Random traffic against the model.
    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      case ($urandom_range(0, 3))
        0:       res_mask = 4'b0000;
        1:       res_mask = 4'b1111;
        default: res_mask = 4'($urandom);
      endcase
      res_valid = ($urandom_range(0, 9) < 7);
      res_addr  = 5'($urandom);
      res_data  = {$urandom, $urandom, $urandom, $urandom};
    end
    @(negedge clk); res_valid = 0;
    repeat (10) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
